// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART transmit definitions: FSM state encodings and parity-type constants.
package uart_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity bit generator: XOR reduction of the payload, inverted for odd parity.
module uart_parity_calc
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    assign o_parity = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame transmitter: start bit, LSB-first payload, optional parity, one stop bit.
// Outputs are registered from next-state values so they change on the same edge as the state.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  i_tx_ctrl_clk,
    input  logic                  i_tx_ctrl_rst,
    input  logic                  i_tx_ctrl_start,
    input  logic [DATA_WIDTH-1:0] i_tx_ctrl_data,
    input  logic                  i_tx_ctrl_par_en,
    input  logic                  i_tx_ctrl_par_typ,
    output logic                  o_tx_ctrl_serial,
    output logic                  o_tx_ctrl_busy,
    output logic                  o_tx_ctrl_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_serial;
    logic                  r_busy;
    logic                  r_done;

    tx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_bit_end;
    logic                  w_latch;
    logic                  w_parity;
    logic                  w_serial_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_latch   = (r_state == ST_IDLE) && i_tx_ctrl_start;

    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .i_data    (r_data),
        .i_par_typ (r_par_typ),
        .o_parity  (w_parity)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_tx_ctrl_clk or posedge i_tx_ctrl_rst) begin
        if (i_tx_ctrl_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_serial <= w_serial_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            if (w_latch) begin
                r_data    <= i_tx_ctrl_data;
                r_par_en  <= i_tx_ctrl_par_en;
                r_par_typ <= i_tx_ctrl_par_typ;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (i_tx_ctrl_start) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the serial line moves on the bit edge itself.
    always_comb begin
        w_serial_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
        w_done_nxt   = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = (r_state == ST_STOP);
            end
            ST_START:  w_serial_nxt = 1'b0;
            ST_DATA:   w_serial_nxt = r_data[w_idx_nxt];
            ST_PARITY: w_serial_nxt = w_parity;
            ST_STOP:   w_serial_nxt = 1'b1;
            default:   w_busy_nxt   = 1'b0;
        endcase
    end

    assign o_tx_ctrl_serial = r_serial;
    assign o_tx_ctrl_busy   = r_busy;
    assign o_tx_ctrl_done   = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frames are compared cycle by cycle against hand-written bit patterns.
module tb_uart_tx_ctrl;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       serial;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_tx_ctrl_clk     (clk),
        .i_tx_ctrl_rst     (rst),
        .i_tx_ctrl_start   (start),
        .i_tx_ctrl_data    (data),
        .i_tx_ctrl_par_en  (par_en),
        .i_tx_ctrl_par_typ (par_typ),
        .o_tx_ctrl_serial  (serial),
        .o_tx_ctrl_busy    (busy),
        .o_tx_ctrl_done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts a frame at the current falling edge; sample j is taken after rising edge k+j.
    // exp_bits holds the frame in transmit order (bit 0 = start bit).
    // junk_* are cycle offsets at which a stray start is sampled; chain returns in the done cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                             input logic [10:0] exp_bits, input int junk_a, input int junk_b,
                             input int junk_c, input bit chain);
        int len;
        len     = (pe ? 11 : 10) * CPB;
        start   = 1'b1;
        data    = d;
        par_en  = pe;
        par_typ = pt;
        @(negedge clk);
        data    = ~d;
        par_en  = ~pe;
        par_typ = ~pt;
        for (int j = 0; j <= len; j++) begin
            if (j < len) begin
                check($sformatf("%s.ser@%0d", tag, j), serial, exp_bits[j / CPB]);
                check($sformatf("%s.busy@%0d", tag, j), busy, 1'b1);
                check($sformatf("%s.done@%0d", tag, j), done, 1'b0);
            end else begin
                check($sformatf("%s.ser_end", tag), serial, 1'b1);
                check($sformatf("%s.busy_end", tag), busy, 1'b0);
                check($sformatf("%s.done_end", tag), done, 1'b1);
            end
            if (j == len && chain) return;
            start = (j + 1 == junk_a) || (j + 1 == junk_b) || (j + 1 == junk_c);
            @(negedge clk);
        end
        check($sformatf("%s.ser_idle", tag), serial, 1'b1);
        check($sformatf("%s.busy_idle", tag), busy, 1'b0);
        check($sformatf("%s.done_clr", tag), done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        data    = 8'h00;
        par_en  = 1'b0;
        par_typ = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.ser", serial, 1'b1);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);

        start = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        check("rst_start.ser", serial, 1'b1);
        check("rst_start.busy", busy, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle.ser", serial, 1'b1);
        check("idle.busy", busy, 1'b0);

        run_frame("f55",  8'h55, 1'b0, 1'b0, 11'b01010101010, -1, -1, -1, 1'b0);
        run_frame("fA3e", 8'hA3, 1'b1, 1'b0, 11'b10101000110, -1, -1, -1, 1'b0);
        run_frame("fA3o", 8'hA3, 1'b1, 1'b1, 11'b11101000110, -1, -1, -1, 1'b0);
        run_frame("junk", 8'h55, 1'b0, 1'b0, 11'b01010101010, 5, 80, 160, 1'b0);

        run_frame("b2b1", 8'h55, 1'b0, 1'b0, 11'b01010101010, -1, -1, -1, 1'b1);
        run_frame("b2b2", 8'h0F, 1'b0, 1'b0, 11'b01000011110, -1, -1, -1, 1'b0);

        start  = 1'b1;
        data   = 8'h55;
        par_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j < 40; j++) @(negedge clk);
        check("mid.ser_pre", serial, 1'b0);
        check("mid.busy_pre", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid.ser_rst", serial, 1'b1);
        check("mid.busy_rst", busy, 1'b0);
        check("mid.done_rst", done, 1'b0);
        start = 1'b1;
        @(negedge clk);
        check("mid.ser_hold", serial, 1'b1);
        check("mid.busy_hold", busy, 1'b0);
        rst = 1'b0;
        run_frame("post", 8'h55, 1'b0, 1'b0, 11'b01010101010, -1, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range >= 2.
REQ-003 SHALL have port i_tx_ctrl_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_tx_ctrl_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_tx_ctrl_start  input  1  one-cycle request pulse from the upstream level-to-pulse stage.
REQ-006 SHALL have port i_tx_ctrl_data  input  DATA_WIDTH  payload, sampled with start.
REQ-007 SHALL have port i_tx_ctrl_par_en  input  1  1 = append parity bit.
REQ-008 SHALL have port i_tx_ctrl_par_typ  input  1  0 = even, 1 = odd.
REQ-009 SHALL have port o_tx_ctrl_serial  output  1  registered serial line, idle high.
REQ-010 SHALL have port o_tx_ctrl_busy  output  1  high while a frame is in progress.
REQ-011 SHALL have port o_tx_ctrl_done  output  1  one-cycle pulse at frame end.

Function
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL, in IDLE with start=1 at edge k, latch data, par_en and par_typ, enter START, and drive serial=0 and busy=1 from edge k.
REQ-014 SHALL hold each bit (start, each data bit, parity, stop) for exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that clears on every bit boundary.
REQ-015 SHALL send data LSB first, using a bit index that advances 0 to DATA_WIDTH-1 and then clears.
REQ-016 SHALL go from DATA to PARITY when the latched par_en=1, and to STOP otherwise.
REQ-017 SHALL compute parity as XOR of the latched data for even, and its inverse for odd.
REQ-018 SHALL drive serial=1 in STOP and IDLE.
REQ-019 SHALL, at the edge ending the stop bit, enter IDLE, set busy=0, and pulse done=1 for exactly one cycle.
REQ-020 SHALL ignore start whenever state != IDLE, including the STOP-to-IDLE edge; no queuing.
REQ-021 SHALL accept start in the done cycle, giving a minimum inter-frame idle of 1 cycle.
REQ-022 SHALL ignore changes on data, par_en and par_typ after latching; the frame in flight is unaffected.
REQ-023 SHALL produce frame length (1 + DATA_WIDTH + par_en + 1) * CLKS_PER_BIT cycles.

Reset
REQ-024 SHALL, on reset asserted at any time including mid-frame, immediately force state=IDLE, serial=1, busy=0, done=0, and all counters and latches to 0.
REQ-025 SHALL accept no start while reset is high, and SHALL accept start from the first edge after deassertion.

Structure
REQ-026 SHALL take FSM state encodings and parity-type constants (EVEN=0, ODD=1) from the shared UART definitions package.
REQ-027 SHALL place parity generation in sub-module uart_parity_calc (data, type -> bit), instantiated once.

Verification
REQ-028 SHALL verify: reset asserted at cycle 40 of a 0x55 frame -> serial=1, busy=0 immediately; next start yields a clean full frame.
REQ-029 SHALL verify: data=0x55, par_en=0, CLKS_PER_BIT=16 -> serial 0, 1,0,1,0,1,0,1,0, 1, each 16 cycles; busy high for 160 cycles; done pulses once at edge 160.
REQ-030 SHALL verify: data=0xA3, par_en=1, par_typ=0 -> parity bit 0; frame 176 cycles.
REQ-031 SHALL verify: data=0xA3, par_en=1, par_typ=1 -> parity bit 1.
REQ-032 SHALL verify: start pulses at cycles 5 and 80 of a frame, and on the STOP-to-IDLE edge -> all ignored; serial and done unchanged.
REQ-033 SHALL verify: start in the done cycle with data=0x0F -> start bit begins next edge; exactly 1 idle-high cycle between frames; second frame bit-exact.
